// File: rtl/dctlb_req_arb.sv
// -----------------------------------------------------------------------------
// dctlb_req_arb
//
// Request arbiter in front of the data-TLB lookup pipe. Two core request
// ports and one L1 snoop port compete for a single registered output slot.
// Snoops normally win, but after MAX_SNOOP_RUN consecutive snoop grants while
// a core request was waiting, the next slot goes to a core port. The two core
// ports share their slots round-robin.
//
// Ports
//   clk                      : clock, all state on the rising edge
//   reset                    : asynchronous, active-low reset
//   coretodctlb_req0_valid   : core port 0 request valid
//   coretodctlb_req0_retry   : core port 0 not accepted this cycle
//   coretodctlb_req0         : core port 0 payload [REQ_W]
//   coretodctlb_req1_valid   : core port 1 request valid
//   coretodctlb_req1_retry   : core port 1 not accepted this cycle
//   coretodctlb_req1         : core port 1 payload [REQ_W]
//   l1todctlb_snoop_valid    : snoop valid
//   l1todctlb_snoop_retry    : snoop not accepted this cycle
//   l1todctlb_snoop          : snoop payload [SNP_W], zero-extended on output
//   arbtodctlb_valid         : granted request valid (registered)
//   arbtodctlb_retry         : downstream stall
//   arbtodctlb_data          : granted payload [REQ_W]
//   arbtodctlb_src           : 0 = req0, 1 = req1, 2 = snoop
// -----------------------------------------------------------------------------
module dctlb_req_arb #(
    parameter int REQ_W         = 64,
    parameter int SNP_W         = 48,
    parameter int MAX_SNOOP_RUN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coretodctlb_req0_valid,
    output logic             coretodctlb_req0_retry,
    input  logic [REQ_W-1:0] coretodctlb_req0,
    input  logic             coretodctlb_req1_valid,
    output logic             coretodctlb_req1_retry,
    input  logic [REQ_W-1:0] coretodctlb_req1,
    input  logic             l1todctlb_snoop_valid,
    output logic             l1todctlb_snoop_retry,
    input  logic [SNP_W-1:0] l1todctlb_snoop,
    output logic             arbtodctlb_valid,
    input  logic             arbtodctlb_retry,
    output logic [REQ_W-1:0] arbtodctlb_data,
    output logic [1:0]       arbtodctlb_src
);

    localparam int unsigned      CNT_W    = $clog2(MAX_SNOOP_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(MAX_SNOOP_RUN);
    localparam logic [1:0]       SRC_REQ0 = 2'd0;
    localparam logic [1:0]       SRC_REQ1 = 2'd1;
    localparam logic [1:0]       SRC_SNP  = 2'd2;

    // Output register and arbitration state
    logic             out_valid_q,  out_valid_d;
    logic [REQ_W-1:0] data_q,       data_d;
    logic [1:0]       src_q,        src_d;
    logic             rr_ptr_q,     rr_ptr_d;      // 0: req0 preferred, 1: req1
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;  // snoop wins while a core waits

    logic load;
    logic any_core;
    logic snp_allowed;
    logic pick_snp, pick_req0, pick_req1, pick_any;

    // The slot can accept a new entry when empty or when it drains this cycle.
    assign load     = !out_valid_q || !arbtodctlb_retry;
    assign any_core = coretodctlb_req0_valid || coretodctlb_req1_valid;

    // A snoop may go ahead of waiting core requests only a limited number of
    // times in a row; with no core request pending it is never held back.
    assign snp_allowed = (starve_cnt_q < RUN_MAX) || !any_core;

    // Candidate selection; it only takes effect when load is high. Only
    // valid bits and state feed this, never payloads, so the retries stay
    // independent of the data path.
    always_comb begin
        pick_snp  = 1'b0;
        pick_req0 = 1'b0;
        pick_req1 = 1'b0;
        if (l1todctlb_snoop_valid && snp_allowed) begin
            pick_snp = 1'b1;
        end else if (!rr_ptr_q) begin
            if (coretodctlb_req0_valid) begin
                pick_req0 = 1'b1;
            end else if (coretodctlb_req1_valid) begin
                pick_req1 = 1'b1;
            end
        end else begin
            if (coretodctlb_req1_valid) begin
                pick_req1 = 1'b1;
            end else if (coretodctlb_req0_valid) begin
                pick_req0 = 1'b1;
            end
        end
    end

    assign pick_any = pick_snp || pick_req0 || pick_req1;

    // Reset is folded in so every producer is pushed back while the block is
    // held in reset, independent of the flop contents.
    assign coretodctlb_req0_retry = !(reset && load && pick_req0);
    assign coretodctlb_req1_retry = !(reset && load && pick_req1);
    assign l1todctlb_snoop_retry  = !(reset && load && pick_snp);

    always_comb begin
        out_valid_d  = out_valid_q;
        data_d       = data_q;
        src_d        = src_q;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        if (load) begin
            // With nothing to grant the slot empties but data/src keep their
            // last values, which avoids toggling the wide data bus.
            out_valid_d = pick_any;
            if (pick_snp) begin
                data_d = REQ_W'(l1todctlb_snoop);
                src_d  = SRC_SNP;
                if (any_core) begin
                    if (starve_cnt_q != RUN_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end else if (pick_req0) begin
                data_d       = coretodctlb_req0;
                src_d        = SRC_REQ0;
                rr_ptr_d     = 1'b1;
                starve_cnt_d = '0;
            end else if (pick_req1) begin
                data_d       = coretodctlb_req1;
                src_d        = SRC_REQ1;
                rr_ptr_d     = 1'b0;
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            src_q        <= SRC_REQ0;
            rr_ptr_q     <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            data_q       <= data_d;
            src_q        <= src_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign arbtodctlb_valid = out_valid_q;
    assign arbtodctlb_data  = data_q;
    assign arbtodctlb_src   = src_q;

endmodule

// File: tb/tb_dctlb_req_arb.sv
// -----------------------------------------------------------------------------
// tb_dctlb_req_arb
//
// Scoreboard bench for dctlb_req_arb. The driver applies inputs just after the
// rising edge, checks input retries and output state against a reference model
// and pushes each expected grant into a queue; a monitor on the falling edge
// pops and compares every entry the DUT hands downstream.
// -----------------------------------------------------------------------------
module tb_dctlb_req_arb;

    localparam int REQ_W = 64;
    localparam int SNP_W = 48;
    localparam int MSR   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             v0, v1, vs;
    logic             r0, r1, rs;
    logic [REQ_W-1:0] d0, d1;
    logic [SNP_W-1:0] ds;
    logic             out_v;
    logic             ds_ret;
    logic [REQ_W-1:0] out_d;
    logic [1:0]       out_s;

    dctlb_req_arb #(.REQ_W(REQ_W), .SNP_W(SNP_W), .MAX_SNOOP_RUN(MSR)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .coretodctlb_req0_valid (v0),
        .coretodctlb_req0_retry (r0),
        .coretodctlb_req0       (d0),
        .coretodctlb_req1_valid (v1),
        .coretodctlb_req1_retry (r1),
        .coretodctlb_req1       (d1),
        .l1todctlb_snoop_valid  (vs),
        .l1todctlb_snoop_retry  (rs),
        .l1todctlb_snoop        (ds),
        .arbtodctlb_valid       (out_v),
        .arbtodctlb_retry       (ds_ret),
        .arbtodctlb_data        (out_d),
        .arbtodctlb_src         (out_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Expected entries as {src, data}, oldest first.
    logic [REQ_W+1:0] sb_q[$];

    // Reference model: the slot contents plus two counters describing fairness.
    bit               m_ov;
    logic [REQ_W-1:0] m_data;
    logic [1:0]       m_src;
    int               m_pref;   // core port that goes first on the next core slot
    int               m_run;    // snoop grants in a row while a core port waited
    int               last_g;   // channel transferred at the last edge, -1 none

    task automatic chk(input string name, input logic [REQ_W+1:0] act, input logic [REQ_W+1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_ov = 0; m_data = '0; m_src = 2'd0; m_pref = 0; m_run = 0; last_g = -1;
    endtask

    // Which channel should win this cycle: -1 none, 0/1 core ports, 2 snoop.
    function automatic int model_pick();
        int order[2];
        if (m_ov && ds_ret) return -1;
        if (vs && (m_run < MSR || !(v0 || v1))) return 2;
        order[0] = m_pref;
        order[1] = 1 - m_pref;
        foreach (order[i]) begin
            if (order[i] == 0 && v0) return 0;
            if (order[i] == 1 && v1) return 1;
        end
        return -1;
    endfunction

    // One clock: check combinational view, cross the edge, advance the model.
    task automatic step();
        int g;
        bit loaded;
        #2;
        g = model_pick();
        loaded = !(m_ov && ds_ret);
        chk("in_retries", {rs, r1, r0}, {g != 2, g != 1, g != 0});
        chk("out_valid", out_v, m_ov);
        if (!m_ov) chk("held_slot", {out_s, out_d}, {m_src, m_data});
        @(posedge clk);
        if (loaded) begin
            if (g < 0) begin
                m_ov = 0;
            end else begin
                m_ov   = 1;
                m_src  = 2'(g);
                m_data = (g == 0) ? d0 : (g == 1) ? d1 : REQ_W'(ds);
                sb_q.push_back({m_src, m_data});
                if (g == 2) m_run = (v0 || v1) ? ((m_run < MSR) ? m_run + 1 : MSR) : 0;
                else begin
                    m_run  = 0;
                    m_pref = 1 - g;
                end
            end
        end
        last_g = g;
        #1;
    endtask

    // Producers hold valid and payload until their transfer; a free producer
    // raises a new request with probability p*/100.
    task automatic drive(input int p0, input int p1, input int ps, input int pr, input int snp_fix);
        if (!v0 || last_g == 0) begin
            v0 = ($urandom_range(99) < p0);
            d0 = {$urandom, $urandom};
        end
        if (!v1 || last_g == 1) begin
            v1 = ($urandom_range(99) < p1);
            d1 = {$urandom, $urandom};
        end
        if (!vs || last_g == 2) begin
            vs = ($urandom_range(99) < ps);
            ds = (snp_fix >= 0) ? SNP_W'(snp_fix) : SNP_W'({$urandom, $urandom});
        end
        ds_ret = ($urandom_range(99) < pr);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, -1);
    endtask

    // Monitor: every entry accepted downstream must match the oldest expected.
    always @(negedge clk) begin
        if (reset && out_v && !ds_ret) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL out_unexpected: got src=%0d data=%0h, required no entry", out_s, out_d);
            end else begin
                chk("out_entry", {out_s, out_d}, sb_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b0;
        v0 = 1'b1; v1 = 1'b1; vs = 1'b0;
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; ds = '0;
        ds_ret = 1'b0;
        model_reset();

        // Held in reset with requests pending: nothing may be accepted.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {out_v, out_s, out_d}, '0);
        chk("rst_retries", {rs, r1, r0}, 3'b111);
        reset = 1'b1;

        // Two core ports streaming: src alternates 0,1,0,1.
        for (int i = 0; i < 12; i++) drive(100, 100, 0, 0, -1);
        idle(4);

        // Snoop and req0 streaming: src 2,2,2,2,0,...
        for (int i = 0; i < 15; i++) drive(100, 0, 100, 0, -1);
        idle(4);

        // Snoop alone with a small payload, zero-extended.
        for (int i = 0; i < 4; i++) drive(0, 0, 100, 0, 'hABC);
        idle(3);

        // Downstream stall for three cycles while req1 waits.
        drive(0, 100, 0, 0, -1);
        for (int i = 0; i < 3; i++) drive(0, 100, 0, 100, -1);
        for (int i = 0; i < 2; i++) drive(0, 100, 0, 0, -1);
        idle(4);

        // Reset while a stalled entry sits in the slot.
        for (int i = 0; i < 3; i++) drive(100, 100, 0, 100, -1);
        chk("pre_rst_slot", m_ov, 1'b1);
        reset = 1'b0;
        #1;
        chk("arst_out", {out_v, out_s, out_d}, '0);
        chk("arst_retries", {rs, r1, r0}, 3'b111);
        model_reset();
        sb_q.delete();
        @(posedge clk);
        #1;
        chk("arst_hold_retries", {rs, r1, r0}, 3'b111);
        chk("arst_hold_valid", out_v, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(100, 100, 0, 0, -1);
        idle(4);

        // Random traffic with varying load and downstream stalls.
        for (int b = 0; b < 8; b++) begin
            int p0, p1, ps, pr;
            p0 = $urandom_range(100);
            p1 = $urandom_range(100);
            ps = $urandom_range(100);
            pr = $urandom_range(60);
            for (int i = 0; i < 50; i++) drive(p0, p1, ps, pr, -1);
        end
        idle(8);

        checks++;
        if (sb_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d entries outstanding, required 0", sb_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dctlb_req_arb.md
DCTLB_REQ_ARB -- requirements
Module: dctlb_req_arb

Interface
REQ-001 SHALL have parameter REQ_W, default 64, width of the core request and granted-request payload.
REQ-002 SHALL have parameter SNP_W, default 48, width of the snoop payload (SNP_W <= REQ_W).
REQ-003 SHALL have parameter MAX_SNOOP_RUN, default 4, the number of consecutive snoop grants allowed while a core request waits.
REQ-004 SHALL have ports, clock and reset first:
  clk  in  1  sole clock; all state on rising edge.
  reset  in  1  asynchronous, active-low reset.
  coretodctlb_req0_valid  in  1  core port 0 request valid.
  coretodctlb_req0_retry  out  1  port 0 not accepted this cycle.
  coretodctlb_req0  in  REQ_W  port 0 payload.
  coretodctlb_req1_valid  in  1  core port 1 request valid.
  coretodctlb_req1_retry  out  1  port 1 not accepted this cycle.
  coretodctlb_req1  in  REQ_W  port 1 payload.
  l1todctlb_snoop_valid  in  1  TLB snoop valid.
  l1todctlb_snoop_retry  out  1  snoop not accepted this cycle.
  l1todctlb_snoop  in  SNP_W  snoop payload.
  arbtodctlb_valid  out  1  granted request valid (registered).
  arbtodctlb_retry  in  1  downstream TLB lookup stalled.
  arbtodctlb_data  out  REQ_W  granted payload.
  arbtodctlb_src  out  2  source: 0=req0, 1=req1, 2=snoop; 3 never driven.

Function
REQ-005 A transfer SHALL occur on any channel only in a cycle where valid=1 and retry=0; a producer holds valid and payload until transfer.
REQ-006 The block SHALL hold a one-entry output register (out_valid, data, src) driving arbtodctlb_*.
REQ-007 load SHALL be (!out_valid || !arbtodctlb_retry); the output register updates only when load=1.
REQ-008 When load=1, a selection SHALL be made among valid inputs in the same cycle; at most one input is granted per cycle.
REQ-009 Snoop SHALL be granted if snoop_valid=1 and (starve_cnt < MAX_SNOOP_RUN or neither core port is valid).
REQ-010 Otherwise the core port indicated by rr_ptr SHALL be granted if valid, else the other core port if valid.
REQ-011 After a core grant, rr_ptr SHALL point to the non-granted port; rr_ptr SHALL be unchanged on snoop grant or no grant.
REQ-012 starve_cnt SHALL increment, saturating at MAX_SNOOP_RUN, on a snoop grant while any core port is valid; SHALL clear on any core grant or on a snoop grant with no core port valid; SHALL hold otherwise.
REQ-013 Each input retry SHALL be combinational: retry = !(load && granted); all non-granted valid inputs see retry=1.
REQ-014 Snoop payload SHALL be zero-extended into arbtodctlb_data[REQ_W-1:0] (snoop in LSBs).
REQ-015 Latency SHALL be 1 cycle: a grant at edge N makes arbtodctlb_valid=1 after edge N.
REQ-016 When load=1 and no input is valid, out_valid SHALL become 0; data/src SHALL hold their previous values.
REQ-017 If arbtodctlb_retry=1 with out_valid=1, the output register SHALL hold unchanged and all input retries SHALL be 1.
REQ-018 Back-to-back transfers SHALL sustain one grant per cycle while arbtodctlb_retry=0.
REQ-019 Input retry outputs SHALL not depend on input payloads; arbtodctlb_valid SHALL not depend combinationally on any input.

Reset
REQ-020 On reset=0, asynchronously: out_valid=0, arbtodctlb_data=0, arbtodctlb_src=0, rr_ptr=0 (req0 preferred), starve_cnt=0.
REQ-021 While reset=0, all three input retries SHALL be 1 and no grant SHALL occur.
REQ-022 Reset asserted mid-operation SHALL discard any held output entry without completing it; first grant is possible on the first rising edge after reset deasserts.

Verification
REQ-023 Bench SHALL cover: req0 and req1 valid continuously, retry=0 -> src sequence 0,1,0,1...; each port's retry alternates 0/1.
REQ-024 Bench SHALL cover: snoop and req0 valid continuously, MAX_SNOOP_RUN=4 -> src 2,2,2,2,0,2,2,2,2,0...
REQ-025 Bench SHALL cover: snoop alone with payload 0xABC -> arbtodctlb_data=0x...000ABC, src=2, next cycle; starve_cnt stays 0.
REQ-026 Bench SHALL cover: out_valid=1, arbtodctlb_retry=1 for 3 cycles with req1 valid -> output frozen, req1_retry=1 for 3 cycles; req1 granted in the cycle retry drops, then appears on the output.
REQ-027 Bench SHALL cover: reset asserted while out_valid=1 and retry=1 -> arbtodctlb_valid=0 immediately (asynchronous), all retries=1; after release req0 wins first (rr_ptr=0).
REQ-028 Bench SHALL cover: no valid inputs with load=1 -> arbtodctlb_valid falls to 0 the next cycle, src/data held.
